mdu_sequencer: RTL
==================

// Module: mdu_sequencer
// PURPOSE
//  Sequences the iterative multiply unit of the pipelined MIPS-lite core: MULTU, MULT, MUL.
//  Sits beside EX. Accepts one op from decode, runs a radix-2 shift-add over WIDTH cycles,
//  commits HI/LO or the MUL writeback, and drives a stall to the hazard/PC-enable logic
//  for structural and HI/LO data hazards.
// PARAMETERS
//  WIDTH      32  operand width; product is 2*WIDTH bits
//  ZERO_SKIP  0   1: finish early once the remaining multiplier bits are all zero
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      synchronous reset, active high
//  start     in   1      decode presents an MDU op this cycle
//  op        in   2      00 MULTU, 01 MULT (signed), 10 MUL (low half to GPR), 11 ignored
//  src_a     in   WIDTH  multiplicand (rs)
//  src_b     in   WIDTH  multiplier (rt)
//  rd_req    in   1      decode holds MFHI/MFLO
//  rd_sel    in   1      0 = LO, 1 = HI
//  flush     in   1      squash the in-flight op
//  stall     out  1      freeze PC/IF/ID (combinational)
//  busy      out  1      state != IDLE
//  done      out  1      1-cycle pulse when an op commits
//  hi        out  WIDTH  HI register
//  lo        out  WIDTH  LO register
//  rd_data   out  WIDTH  rd_sel ? hi : lo (combinational)
//  mul_wb    out  1      1-cycle pulse: mul_data valid for the GPR write
//  mul_data  out  WIDTH  low half of the MUL product; holds its last value
// BEHAVIOUR
//  Reset: state=IDLE; hi, lo, mul_data = 0; done, mul_wb = 0; internal counter and
//  accumulators = 0. rst mid-operation aborts with no done and no commit.
//  FSM: IDLE -> RUN -> FINISH -> IDLE.
//   IDLE:   start & !flush & op!=11 -> latch operands and op; count=0; acc=0; go to RUN.
//           For MULT: store |src_a|, |src_b| and sign = a[W-1]^b[W-1].
//           MULTU/MUL: operands taken unsigned.
//   RUN:    each cycle, if mplier[0], acc += mcand (2W-bit add).
//           Then mcand <<= 1, mplier >>= 1, count++.
//           Go to FINISH after count==WIDTH-1 is processed.
//           With ZERO_SKIP=1, also go to FINISH in any cycle where the shifted mplier is 0.
//   FINISH: product = sign ? -acc : acc (2W-bit two's complement). On exit:
//           MULTU/MULT: hi=product[2W-1:W], lo=product[W-1:0].
//           MUL: mul_data=product[W-1:0], mul_wb=1; hi/lo unchanged.
//           done=1; go to IDLE.
//  Latency: start sampled at edge N; done/mul_wb high in cycle N+WIDTH+1 (FINISH cycle).
//   hi/lo readable in cycle N+WIDTH+2.
//  Stall = (start & op==10) | (busy & (start | rd_req | cur_op==MUL)).
//   MUL therefore blocks from issue through FINISH inclusive.
//   MFHI/MFLO waits until the cycle after FINISH.
//   A second MDU op waits while busy; start while busy is ignored, and decode re-presents it.
//  rd_req while IDLE: no stall; rd_data is valid in the same cycle.
//  flush in RUN or FINISH: go to IDLE next cycle. No done, no mul_wb, hi/lo/mul_data unchanged.
//  flush & start in IDLE: start ignored.
//  op==11 with start: treated as no-op; no stall, no state change.
//  Signed edge: MULT with 0x80000000 uses magnitude 2^31 (unsigned abs), and the result is exact.
// TESTING
//  1 ZERO_SKIP=0: MULTU 0xFFFFFFFF*0xFFFFFFFF -> done at N+33; hi=0xFFFFFFFE, lo=0x00000001.
//  2 MULT 0xFFFFFFFD(-3)*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//    MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
//  3 MUL 6*7 -> stall high from issue cycle through FINISH; mul_wb pulse with mul_data=42.
//    hi/lo keep the prior values from test 2.
//  4 MULT 5*5 then rd_req=1, rd_sel=0 at N+3 -> stall held through N+33, low at N+34.
//    rd_data=25 at N+34.
//  5 MULTU 9*9 with flush at N+10 -> IDLE at N+11, no done, hi/lo unchanged.
//    flush+start same cycle -> stays IDLE.
//  6 ZERO_SKIP=1: MULTU 0x1234*0 -> done at N+2, hi=lo=0.
//    rst at N+5 of a full run -> IDLE, hi=lo=0, no done.

Source files
------------

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: radix-2 shift-add sequencer for MULTU/MULT/MUL with HI/LO, MUL writeback and hazard stall
module mdu_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter bit ZERO_SKIP = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             rd_req,
  input  logic             rd_sel,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data,
  output logic             mul_wb,
  output logic [WIDTH-1:0] mul_data
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  localparam int CW = $clog2(WIDTH);
  state_t state, state_nx;
  logic [1:0] cur_op;
  logic sign, go, last;
  logic [2*WIDTH-1:0] acc, mcand, acc_nx, product;
  logic [WIDTH-1:0] mplier, mplier_sh, abs_a, abs_b, mul_q;
  logic [CW-1:0] count;
  always_comb begin
    go = start & !flush & (op != 2'b11);
    abs_a = (op == 2'b01 && src_a[WIDTH-1]) ? -src_a : src_a;
    abs_b = (op == 2'b01 && src_b[WIDTH-1]) ? -src_b : src_b;
    mplier_sh = mplier >> 1;
    last = (count == CW'(WIDTH - 1)) | (ZERO_SKIP && mplier_sh == '0);
    acc_nx = mplier[0] ? acc + mcand : acc;
    product = sign ? -acc : acc;
    state_nx = state == IDLE ? (go ? RUN : IDLE) :
               flush         ? IDLE :
               state == RUN  ? (last ? FINISH : RUN) : IDLE;
    busy = state != IDLE;
    done = (state == FINISH) & !flush;
    mul_wb = done & (cur_op == 2'b10);
    stall = (start & (op == 2'b10)) | (busy & (start | rd_req | (cur_op == 2'b10)));
    rd_data = rd_sel ? hi : lo;
    // MUL result is presented during FINISH so the GPR write sees it with mul_wb
    mul_data = (state == FINISH && cur_op == 2'b10) ? product[WIDTH-1:0] : mul_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cur_op <= '0;
      sign <= 1'b0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      count <= '0;
      hi <= '0;
      lo <= '0;
      mul_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && go) begin
        cur_op <= op;
        sign <= (op == 2'b01) & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
        acc <= '0;
        mcand <= {{WIDTH{1'b0}}, abs_a};
        mplier <= abs_b;
        count <= '0;
      end
      if (state == RUN) begin
        acc <= acc_nx;
        mcand <= mcand << 1;
        mplier <= mplier_sh;
        count <= count + CW'(1);
      end
      if (done && cur_op == 2'b10) mul_q <= product[WIDTH-1:0];
      if (done && cur_op != 2'b10) begin
        hi <= product[2*WIDTH-1:WIDTH];
        lo <= product[WIDTH-1:0];
      end
    end
  end
endmodule
